// File: rtl/insn_queue_pkg.sv
// Shared CPU constants and the instruction-queue entry type.
// Queue entries are always CPU_XLEN wide; the insn_queue XLEN parameter must equal CPU_XLEN.
package insn_queue_pkg;

  localparam int CPU_XLEN    = 32;
  localparam int FETCH_WIDTH = 4;
  localparam int ISSUE_WIDTH = 2;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    logic [CPU_XLEN-1:0] insn;
  } iq_entry_t;

  // Useful words in an aligned fetch line that starts at word `start`.
  function automatic logic [2:0] fetch_count(input logic [1:0] start);
    return 3'(FETCH_WIDTH) - {1'b0, start};
  endfunction

endpackage

// File: rtl/insn_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// The slave modport is the queue's view; the master modport is the fetch/decode side.
interface insn_queue_if
  import insn_queue_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
);

  logic                        ic_valid;
  logic [XLEN-1:0]             ic_pc;
  logic [FETCH_WIDTH*XLEN-1:0] ic_insn;
  logic                        iq_allin;

  logic                        id_valid0;
  logic [XLEN-1:0]             id_pc0;
  logic [XLEN-1:0]             id_insn0;
  logic                        id_valid1;
  logic [XLEN-1:0]             id_pc1;
  logic [XLEN-1:0]             id_insn1;
  logic [1:0]                  id_take;

  modport slave (
    input  ic_valid, ic_pc, ic_insn, id_take,
    output iq_allin, id_valid0, id_pc0, id_insn0, id_valid1, id_pc1, id_insn1
  );

  modport master (
    output ic_valid, ic_pc, ic_insn, id_take,
    input  iq_allin, id_valid0, id_pc0, id_insn0, id_valid1, id_pc1, id_insn1
  );

endinterface

// File: rtl/insn_queue_align.sv
// iq_align: packs the useful words of an aligned fetch line (from word ic_pc[3:2]
// up to word 3) into consecutive entries, each tagged with its own PC.
module iq_align
  import insn_queue_pkg::*;
(
  input  logic [CPU_XLEN-1:0]               ic_pc,
  input  logic [FETCH_WIDTH*CPU_XLEN-1:0]   ic_insn,
  output iq_entry_t [FETCH_WIDTH-1:0]       entries,
  output logic [FETCH_WIDTH-1:0]            mask,
  output logic [2:0]                        n
);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the loop infers a latch.
    entries = '0;
    mask    = '0;
    n       = fetch_count(ic_pc[3:2]);
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k + int'(ic_pc[3:2]) < FETCH_WIDTH) begin
        mask[k]         = 1'b1;
        entries[k].pc   = ic_pc + CPU_XLEN'(4 * k);
        entries[k].insn = ic_insn[(k + int'(ic_pc[3:2])) * CPU_XLEN +: CPU_XLEN];
      end
    end
  end

endmodule

// File: rtl/insn_queue.sv
// Dual-issue instruction queue: circular store between icache fetch and decode,
// up to four words in per cycle, two oldest presented to decode, cleared on flush.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = CPU_XLEN
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   flush,
  insn_queue_if.slave            iq,
  output logic [$clog2(DEPTH):0] iq_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  iq_entry_t mem_q [DEPTH];

  iq_entry_t [FETCH_WIDTH-1:0] pkt_entry;
  logic [FETCH_WIDTH-1:0]      pkt_mask;
  logic [2:0]                  pkt_n;

  logic      allin;
  logic      enq;
  iq_entry_t rd0, rd1;

  iq_align u_align (
    .ic_pc   (iq.ic_pc),
    .ic_insn (iq.ic_insn),
    .entries (pkt_entry),
    .mask    (pkt_mask),
    .n       (pkt_n)
  );

  // Ready looks only at registered occupancy; a same-cycle dequeue earns no credit.
  assign allin = (count_q <= (PTR_W+1)'(DEPTH - FETCH_WIDTH));
  assign enq   = iq.ic_valid && allin && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(iq.id_take);
      if (enq) tail_d = tail_q + PTR_W'(pkt_n);
      count_d = count_q + (enq ? (PTR_W+1)'(pkt_n) : '0) - (PTR_W+1)'(iq.id_take);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the store has no reset; count_q gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (pkt_mask[k]) mem_q[tail_q + PTR_W'(k)] <= pkt_entry[k];
      end
    end
  end

  always_comb begin
    rd0 = mem_q[head_q];
    rd1 = mem_q[head_q + PTR_W'(1)];
  end

  assign iq.iq_allin  = allin;
  assign iq.id_valid0 = (count_q >= (PTR_W+1)'(1));
  assign iq.id_valid1 = (count_q >= (PTR_W+1)'(2));
  assign iq.id_pc0    = XLEN'(rd0.pc);
  assign iq.id_insn0  = XLEN'(rd0.insn);
  assign iq.id_pc1    = XLEN'(rd1.pc);
  assign iq.id_insn1  = XLEN'(rd1.insn);
  assign iq_count     = count_q;

endmodule

// File: tb/tb_insn_queue.sv
// Scoreboard bench for insn_queue: accepted words are pushed in order, retired
// words popped, and the two decode slots compared against the queue front.
module tb_insn_queue;
  import insn_queue_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_;
  logic       flush;
  logic [4:0] iq_count;

  insn_queue_if #(.XLEN(32)) iq ();

  insn_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .flush    (flush),
    .iq       (iq),
    .iq_count (iq_count)
  );

  always #5 clk = ~clk;

  iq_entry_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Decode must never take more than is valid.
  always @(negedge clk) begin
    if (rst_) begin
      assert (iq.id_take <= 2'({1'b0, iq.id_valid0} + {1'b0, iq.id_valid1}))
        else $error("illegal id_take %0d", iq.id_take);
    end
  end

  task automatic compare_outputs();
    check("iq_count", iq_count, sb.size());
    check("iq_allin", iq.iq_allin, (DEPTH - sb.size()) >= 4);
    check("id_valid0", iq.id_valid0, sb.size() >= 1);
    check("id_valid1", iq.id_valid1, sb.size() >= 2);
    if (sb.size() >= 1) begin
      check("id_pc0", iq.id_pc0, sb[0].pc);
      check("id_insn0", iq.id_insn0, sb[0].insn);
    end
    if (sb.size() >= 2) begin
      check("id_pc1", iq.id_pc1, sb[1].pc);
      check("id_insn1", iq.id_insn1, sb[1].insn);
    end
  endtask

  // One clock: drive, compare at negedge, advance the model, return after the edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [127:0] words,
                       input int take_req, input logic fl, output logic accepted);
    int take;
    int start;
    take  = (take_req > sb.size()) ? sb.size() : take_req;
    if (take > 2) take = 2;
    start = int'(pc[3:2]);
    iq.ic_valid = v;
    iq.ic_pc    = pc;
    iq.ic_insn  = words;
    iq.id_take  = 2'(take);
    flush       = fl;
    @(negedge clk);
    compare_outputs();
    accepted = v && ((DEPTH - sb.size()) >= 4) && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      for (int i = 0; i < take; i++) void'(sb.pop_front());
      if (accepted) begin
        for (int k = 0; k < 4 - start; k++)
          sb.push_back('{pc: pc + 32'(4 * k), insn: words[(start + k) * 32 +: 32]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        acc;
    logic [127:0] held;

    rst_        = 1'b0;
    flush       = 1'b0;
    iq.ic_valid = 1'b0;
    iq.ic_pc    = '0;
    iq.ic_insn  = '0;
    iq.id_take  = '0;
    #8;
    check("rst_count", iq_count, 0);
    check("rst_allin", iq.iq_allin, 1);
    check("rst_valid0", iq.id_valid0, 0);
    #4 rst_ = 1'b1;
    @(posedge clk);
    #1;

    // Aligned four-word packet, then a two-word packet starting at word 2.
    cycle(1'b1, 32'hBFC0_0000, rand_line(), 0, 1'b0, acc);
    cycle(1'b0, 32'h0, '0, 0, 1'b0, acc);
    check("slot0_pc_const", iq.id_pc0, 32'hBFC0_0000);
    check("slot1_pc_const", iq.id_pc1, 32'hBFC0_0004);
    cycle(1'b1, 32'hBFC0_0008, rand_line(), 0, 1'b0, acc);
    cycle(1'b0, 32'h0, '0, 0, 1'b0, acc);

    // Fill to 13, then hold packets against back-pressure.
    cycle(1'b1, 32'hBFC0_0010, rand_line(), 0, 1'b0, acc);
    cycle(1'b1, 32'hBFC0_0024, rand_line(), 0, 1'b0, acc);
    held = rand_line();
    cycle(1'b1, 32'hBFC0_0030, held, 0, 1'b0, acc);
    cycle(1'b1, 32'hBFC0_0030, held, 2, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cycle(1'b1, 32'hBFC0_0030, held, 0, 1'b0, acc);
    check("held_pkt_p", acc, 1'b1);
    held = rand_line();
    acc  = 1'b0;
    for (int i = 0; i < 8 && !acc; i++)
      cycle(1'b1, 32'hBFC0_004C, held, (sb.size() > 12) ? 1 : 0, 1'b0, acc);
    check("held_pkt_q", acc, 1'b1);

    // Drain to 5, then simultaneous enqueue of 3 and dequeue of 2.
    for (int i = 0; i < 20 && sb.size() > 5; i++)
      cycle(1'b0, 32'h0, '0, (sb.size() - 5 > 2) ? 2 : sb.size() - 5, 1'b0, acc);
    cycle(1'b1, 32'hBFC0_0054, rand_line(), 2, 1'b0, acc);
    cycle(1'b0, 32'h0, '0, 0, 1'b0, acc);

    // Random traffic exercises pointer wrap-around many times.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC, rand_line(),
            $urandom_range(0, 2), $urandom_range(0, 31) == 0, acc);

    // Flush at count 7 with a packet and a take presented.
    cycle(1'b0, 32'h0, '0, 0, 1'b1, acc);
    cycle(1'b1, 32'h8000_0000, rand_line(), 0, 1'b0, acc);
    cycle(1'b1, 32'h8000_0014, rand_line(), 0, 1'b0, acc);
    cycle(1'b1, 32'h8000_0040, rand_line(), 2, 1'b1, acc);
    cycle(1'b0, 32'h0, '0, 0, 1'b0, acc);
    check("flush_count", iq_count, 0);

    // Asynchronous reset mid-stream.
    cycle(1'b1, 32'h9000_0000, rand_line(), 0, 1'b0, acc);
    cycle(1'b1, 32'h9000_0010, rand_line(), 1, 1'b0, acc);
    #2 rst_ = 1'b0;
    #1;
    check("arst_count", iq_count, 0);
    check("arst_allin", iq.iq_allin, 1);
    check("arst_valid0", iq.id_valid0, 0);
    check("arst_valid1", iq.id_valid1, 0);
    sb.delete();
    iq.ic_valid = 1'b0;
    iq.id_take  = '0;
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'hA000_0004, rand_line(), 0, 1'b0, acc);
    cycle(1'b0, 32'h0, '0, 2, 1'b0, acc);
    cycle(1'b0, 32'h0, '0, 0, 1'b0, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
